// File: rtl/dbg_guv_mc.sv
// dbg_guv_mc: multi-channel debug governor.
// One command address controls pause/pass, drop and log for N_CHAN AXI
// streams. Logged flits from every channel are merged round-robin into a
// single log stream tagged with the source channel. Commands addressed to
// other cores are forwarded on cmd_out.
module dbg_guv_mc #(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 16,
    parameter int ID_WIDTH   = 16,
    parameter int N_CHAN     = 2,
    parameter int CNT_SIZE   = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int ADDR       = 0,
    parameter int PIPE_STAGE = 0,
    localparam int CH_W      = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
    localparam int KEEP_W    = DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        cmd_in_TDATA,
    input  logic                         cmd_in_TVALID,
    output logic [DATA_WIDTH-1:0]        cmd_out_TDATA,
    output logic                         cmd_out_TVALID,
    input  logic [N_CHAN*DATA_WIDTH-1:0] in_TDATA,
    input  logic [N_CHAN*KEEP_W-1:0]     in_TKEEP,
    input  logic [N_CHAN*DEST_WIDTH-1:0] in_TDEST,
    input  logic [N_CHAN*ID_WIDTH-1:0]   in_TID,
    input  logic [N_CHAN-1:0]            in_TLAST,
    input  logic [N_CHAN-1:0]            in_TVALID,
    output logic [N_CHAN-1:0]            in_TREADY,
    output logic [N_CHAN*DATA_WIDTH-1:0] out_TDATA,
    output logic [N_CHAN*KEEP_W-1:0]     out_TKEEP,
    output logic [N_CHAN*DEST_WIDTH-1:0] out_TDEST,
    output logic [N_CHAN*ID_WIDTH-1:0]   out_TID,
    output logic [N_CHAN-1:0]            out_TLAST,
    output logic [N_CHAN-1:0]            out_TVALID,
    input  logic [N_CHAN-1:0]            out_TREADY,
    output logic [DATA_WIDTH+KEEP_W-1:0] log_catted_TDATA,
    output logic [CH_W-1:0]              log_catted_TDEST,
    output logic                         log_catted_TLAST,
    output logic                         log_catted_TVALID,
    input  logic                         log_catted_TREADY
);

    // Command field decode
    logic [3:0]            cmd_reg;
    logic [CH_W-1:0]       cmd_chan;
    logic [ADDR_WIDTH-1:0] cmd_core;
    logic [CNT_SIZE-1:0]   cmd_val;
    logic                  cmd_hit;
    logic                  chan_ok;

    assign cmd_reg  = cmd_in_TDATA[3:0];
    assign cmd_chan = cmd_in_TDATA[4 +: CH_W];
    assign cmd_core = cmd_in_TDATA[4+CH_W +: ADDR_WIDTH];
    assign cmd_val  = cmd_in_TDATA[32 +: CNT_SIZE];
    assign cmd_hit  = cmd_in_TVALID && (cmd_core == ADDR_WIDTH'(ADDR));
    assign chan_ok  = (int'(cmd_chan) < N_CHAN);

    // Shadow (written by commands) and active (used for gating) state
    logic [N_CHAN-1:0]   sh_pause_q, sh_drop_q, sh_log_q;
    logic [CNT_SIZE-1:0] sh_pass_q [N_CHAN];
    logic [CNT_SIZE-1:0] sh_dcnt_q [N_CHAN];
    logic [CNT_SIZE-1:0] sh_lcnt_q [N_CHAN];
    logic [N_CHAN-1:0]   act_pause_q, act_drop_q, act_log_q;
    logic [CNT_SIZE-1:0] act_pass_q [N_CHAN];
    logic [CNT_SIZE-1:0] act_dcnt_q [N_CHAN];
    logic [CNT_SIZE-1:0] act_lcnt_q [N_CHAN];

    // One-entry log buffer per channel
    logic [N_CHAN-1:0]     lb_vld_q;
    logic [DATA_WIDTH-1:0] lb_data_q [N_CHAN];
    logic [KEEP_W-1:0]     lb_keep_q [N_CHAN];
    logic [N_CHAN-1:0]     lb_last_q;

    logic [N_CHAN-1:0] open_w, dropping_w, logging_w, slot_ok_w, accept_w, latch_w;
    logic [CH_W-1:0]   rr_q, rr_d, gnt;
    logic              gnt_vld, log_hs;

    // Per-channel gating; sidebands pass straight through
    for (genvar i = 0; i < N_CHAN; i++) begin : g_ch
        assign open_w[i]     = !act_pause_q[i] || (act_pass_q[i] != '0);
        assign dropping_w[i] = act_drop_q[i] || (act_dcnt_q[i] != '0);
        assign logging_w[i]  = act_log_q[i] || (act_lcnt_q[i] != '0);
        // A buffer drained by this cycle's log handshake may be refilled now
        assign slot_ok_w[i]  = !logging_w[i] || !lb_vld_q[i] || (log_hs && (int'(gnt) == i));
        assign in_TREADY[i]  = open_w[i] && slot_ok_w[i] && (dropping_w[i] || out_TREADY[i]);
        assign out_TVALID[i] = in_TVALID[i] && open_w[i] && slot_ok_w[i] && !dropping_w[i];
        assign accept_w[i]   = in_TVALID[i] && in_TREADY[i];
        assign latch_w[i]    = cmd_hit && ((cmd_reg == 4'd14) ||
                               ((cmd_reg == 4'd15) && chan_ok && (int'(cmd_chan) == i)));
    end

    assign out_TDATA = in_TDATA;
    assign out_TKEEP = in_TKEEP;
    assign out_TDEST = in_TDEST;
    assign out_TID   = in_TID;
    assign out_TLAST = in_TLAST;

    // Command register writes, latching and per-flit counter decrements
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_pause_q  <= '0;
            sh_drop_q   <= '0;
            sh_log_q    <= '0;
            act_pause_q <= '0;
            act_drop_q  <= '0;
            act_log_q   <= '0;
            for (int i = 0; i < N_CHAN; i++) begin
                sh_pass_q[i]  <= '0;
                sh_dcnt_q[i]  <= '0;
                sh_lcnt_q[i]  <= '0;
                act_pass_q[i] <= '0;
                act_dcnt_q[i] <= '0;
                act_lcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CHAN; i++) begin
                if (cmd_hit && chan_ok && (int'(cmd_chan) == i)) begin
                    case (cmd_reg)
                        4'd0:    sh_pause_q[i] <= cmd_val[0];
                        4'd1:    sh_drop_q[i]  <= cmd_val[0];
                        4'd2:    sh_log_q[i]   <= cmd_val[0];
                        4'd3:    sh_pass_q[i]  <= cmd_val;
                        4'd4:    sh_dcnt_q[i]  <= cmd_val;
                        4'd5:    sh_lcnt_q[i]  <= cmd_val;
                        default: ;
                    endcase
                end
                // A latch overrides any decrement from the same cycle
                if (latch_w[i]) begin
                    act_pause_q[i] <= sh_pause_q[i];
                    act_drop_q[i]  <= sh_drop_q[i];
                    act_log_q[i]   <= sh_log_q[i];
                    act_pass_q[i]  <= sh_pass_q[i];
                    act_dcnt_q[i]  <= sh_dcnt_q[i];
                    act_lcnt_q[i]  <= sh_lcnt_q[i];
                end else if (accept_w[i]) begin
                    if (act_pause_q[i] && (act_pass_q[i] != '0))
                        act_pass_q[i] <= act_pass_q[i] - 1'b1;
                    if (act_dcnt_q[i] != '0)
                        act_dcnt_q[i] <= act_dcnt_q[i] - 1'b1;
                    if (act_lcnt_q[i] != '0)
                        act_lcnt_q[i] <= act_lcnt_q[i] - 1'b1;
                end
            end
        end
    end

    // Round-robin search over full buffers starting at rr
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < N_CHAN; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_CHAN) idx = idx - N_CHAN;
            if (!gnt_vld && lb_vld_q[idx]) begin
                gnt_vld = 1'b1;
                gnt     = CH_W'(idx);
            end
        end
    end

    assign log_hs            = gnt_vld && log_catted_TREADY;
    assign log_catted_TVALID = gnt_vld;
    assign log_catted_TDEST  = gnt;
    assign log_catted_TDATA  = {lb_keep_q[gnt], lb_data_q[gnt]};
    assign log_catted_TLAST  = lb_last_q[gnt];

    // Next pointer: advance past a served channel, or park on a stalled grant so it holds
    always_comb begin
        rr_d = rr_q;
        if (log_hs)
            rr_d = (int'(gnt) == N_CHAN - 1) ? '0 : gnt + 1'b1;
        else if (gnt_vld)
            rr_d = gnt;
    end

    // Round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) rr_q <= '0;
        else     rr_q <= rr_d;
    end

    // Log buffer occupancy: capture wins over drain for the same channel
    always_ff @(posedge clk) begin
        if (rst) begin
            lb_vld_q <= '0;
        end else begin
            for (int i = 0; i < N_CHAN; i++) begin
                if (accept_w[i] && logging_w[i])
                    lb_vld_q[i] <= 1'b1;
                else if (log_hs && (int'(gnt) == i))
                    lb_vld_q[i] <= 1'b0;
            end
        end
    end

    // Log buffer payload capture (payload needs no reset, occupancy guards it)
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CHAN; i++) begin
            if (accept_w[i] && logging_w[i]) begin
                lb_data_q[i] <= in_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
                lb_keep_q[i] <= in_TKEEP[i*KEEP_W +: KEEP_W];
                lb_last_q[i] <= in_TLAST[i];
            end
        end
    end

    if (PIPE_STAGE != 0) begin : g_cmd_pipe
        // Registered forward of commands for other cores
        always_ff @(posedge clk) begin
            if (rst) cmd_out_TVALID <= 1'b0;
            else     cmd_out_TVALID <= cmd_in_TVALID && !cmd_hit;
            cmd_out_TDATA <= cmd_in_TDATA;
        end
    end else begin : g_cmd_comb
        assign cmd_out_TVALID = cmd_in_TVALID && !cmd_hit;
        assign cmd_out_TDATA  = cmd_in_TDATA;
    end

endmodule

// File: tb/tb_dbg_guv_mc.sv
// Directed self-checking bench for dbg_guv_mc (N_CHAN=2, ADDR=3).
// A second instance with PIPE_STAGE=1 shares the command input.
module tb_dbg_guv_mc;
    localparam int DW = 64, KW = 8, DSTW = 16, IDW = 16, NC = 2, CHW = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [DW-1:0]        cmd_in_TDATA;
    logic                 cmd_in_TVALID;
    logic [DW-1:0]        cmd_out_TDATA;
    logic                 cmd_out_TVALID;
    logic [NC*DW-1:0]     in_TDATA;
    logic [NC*KW-1:0]     in_TKEEP;
    logic [NC*DSTW-1:0]   in_TDEST;
    logic [NC*IDW-1:0]    in_TID;
    logic [NC-1:0]        in_TLAST, in_TVALID, in_TREADY;
    logic [NC*DW-1:0]     out_TDATA;
    logic [NC*KW-1:0]     out_TKEEP;
    logic [NC*DSTW-1:0]   out_TDEST;
    logic [NC*IDW-1:0]    out_TID;
    logic [NC-1:0]        out_TLAST, out_TVALID, out_TREADY;
    logic [DW+KW-1:0]     log_TDATA;
    logic [CHW-1:0]       log_TDEST;
    logic                 log_TLAST, log_TVALID, log_TREADY;

    logic [DW-1:0]        p_cmd_out_TDATA;
    logic                 p_cmd_out_TVALID;
    logic [NC-1:0]        p_in_TREADY, p_out_TLAST, p_out_TVALID;
    logic [NC*DW-1:0]     p_out_TDATA;
    logic [NC*KW-1:0]     p_out_TKEEP;
    logic [NC*DSTW-1:0]   p_out_TDEST;
    logic [NC*IDW-1:0]    p_out_TID;
    logic [DW+KW-1:0]     p_log_TDATA;
    logic [CHW-1:0]       p_log_TDEST;
    logic                 p_log_TLAST, p_log_TVALID;

    int n_checks = 0;
    int n_fail   = 0;

    dbg_guv_mc #(.DATA_WIDTH(DW), .DEST_WIDTH(DSTW), .ID_WIDTH(IDW), .N_CHAN(NC),
                 .CNT_SIZE(16), .ADDR_WIDTH(12), .ADDR(3), .PIPE_STAGE(0)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_in_TDATA(cmd_in_TDATA), .cmd_in_TVALID(cmd_in_TVALID),
        .cmd_out_TDATA(cmd_out_TDATA), .cmd_out_TVALID(cmd_out_TVALID),
        .in_TDATA(in_TDATA), .in_TKEEP(in_TKEEP), .in_TDEST(in_TDEST), .in_TID(in_TID),
        .in_TLAST(in_TLAST), .in_TVALID(in_TVALID), .in_TREADY(in_TREADY),
        .out_TDATA(out_TDATA), .out_TKEEP(out_TKEEP), .out_TDEST(out_TDEST), .out_TID(out_TID),
        .out_TLAST(out_TLAST), .out_TVALID(out_TVALID), .out_TREADY(out_TREADY),
        .log_catted_TDATA(log_TDATA), .log_catted_TDEST(log_TDEST),
        .log_catted_TLAST(log_TLAST), .log_catted_TVALID(log_TVALID),
        .log_catted_TREADY(log_TREADY)
    );

    dbg_guv_mc #(.DATA_WIDTH(DW), .DEST_WIDTH(DSTW), .ID_WIDTH(IDW), .N_CHAN(NC),
                 .CNT_SIZE(16), .ADDR_WIDTH(12), .ADDR(3), .PIPE_STAGE(1)) u_dut_pipe (
        .clk(clk), .rst(rst),
        .cmd_in_TDATA(cmd_in_TDATA), .cmd_in_TVALID(cmd_in_TVALID),
        .cmd_out_TDATA(p_cmd_out_TDATA), .cmd_out_TVALID(p_cmd_out_TVALID),
        .in_TDATA('0), .in_TKEEP('0), .in_TDEST('0), .in_TID('0),
        .in_TLAST('0), .in_TVALID('0), .in_TREADY(p_in_TREADY),
        .out_TDATA(p_out_TDATA), .out_TKEEP(p_out_TKEEP), .out_TDEST(p_out_TDEST), .out_TID(p_out_TID),
        .out_TLAST(p_out_TLAST), .out_TVALID(p_out_TVALID), .out_TREADY('0),
        .log_catted_TDATA(p_log_TDATA), .log_catted_TDEST(p_log_TDEST),
        .log_catted_TLAST(p_log_TLAST), .log_catted_TVALID(p_log_TVALID),
        .log_catted_TREADY(1'b0)
    );

    // One command beat, returning at the negedge after it was sampled
    task automatic send_cmd(input logic [63:0] d);
        @(negedge clk);
        cmd_in_TDATA  = d;
        cmd_in_TVALID = 1'b1;
        @(negedge clk);
        cmd_in_TVALID = 1'b0;
        cmd_in_TDATA  = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst        = 1'b0;
        in_TVALID  = 2'b11;
        out_TREADY = 2'b11;
        in_TDATA   = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        #1;
        n_checks++;
        if (cmd_out_TVALID !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_out_vld: got %b want 0", cmd_out_TVALID); end
        n_checks++;
        if (p_cmd_out_TVALID !== 1'b0) begin n_fail++; $display("FAIL reset_pipe_cmd_vld: got %b want 0", p_cmd_out_TVALID); end
        n_checks++;
        if (log_TVALID !== 1'b0) begin n_fail++; $display("FAIL reset_log_vld: got %b want 0", log_TVALID); end
        n_checks++;
        if (in_TREADY !== 2'b11) begin n_fail++; $display("FAIL reset_in_ready: got %b want 11", in_TREADY); end
        n_checks++;
        if (out_TVALID !== 2'b11) begin n_fail++; $display("FAIL reset_out_vld: got %b want 11", out_TVALID); end
        n_checks++;
        if (out_TDATA !== {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888}) begin
            n_fail++; $display("FAIL reset_out_data: got %h want %h", out_TDATA,
                               {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888});
        end
    endtask

    task automatic test_cmd_fwd;
        // core 4 command: forwarded combinationally, pipelined one cycle later
        @(negedge clk);
        cmd_in_TDATA  = 64'h00000001_00000080;
        cmd_in_TVALID = 1'b1;
        #1;
        n_checks++;
        if (cmd_out_TVALID !== 1'b1) begin n_fail++; $display("FAIL fwd_vld: got %b want 1", cmd_out_TVALID); end
        n_checks++;
        if (cmd_out_TDATA !== 64'h00000001_00000080) begin n_fail++; $display("FAIL fwd_data: got %h want %h", cmd_out_TDATA, 64'h00000001_00000080); end
        n_checks++;
        if (p_cmd_out_TVALID !== 1'b0) begin n_fail++; $display("FAIL fwd_pipe_early: got %b want 0", p_cmd_out_TVALID); end
        @(negedge clk);
        cmd_in_TVALID = 1'b0;
        cmd_in_TDATA  = '0;
        #1;
        n_checks++;
        if (cmd_out_TVALID !== 1'b0) begin n_fail++; $display("FAIL fwd_vld_drop: got %b want 0", cmd_out_TVALID); end
        n_checks++;
        if (p_cmd_out_TVALID !== 1'b1) begin n_fail++; $display("FAIL fwd_pipe_vld: got %b want 1", p_cmd_out_TVALID); end
        n_checks++;
        if (p_cmd_out_TDATA !== 64'h00000001_00000080) begin n_fail++; $display("FAIL fwd_pipe_data: got %h want %h", p_cmd_out_TDATA, 64'h00000001_00000080); end
        // own-core latch of ch0: consumed, and the core-4 pause must not have landed
        @(negedge clk);
        cmd_in_TDATA  = 64'h00000000_0000006F;
        cmd_in_TVALID = 1'b1;
        #1;
        n_checks++;
        if (cmd_out_TVALID !== 1'b0) begin n_fail++; $display("FAIL own_consumed: got %b want 0", cmd_out_TVALID); end
        @(negedge clk);
        cmd_in_TVALID = 1'b0;
        cmd_in_TDATA  = '0;
        #1;
        n_checks++;
        if (p_cmd_out_TVALID !== 1'b0) begin n_fail++; $display("FAIL own_pipe_consumed: got %b want 0", p_cmd_out_TVALID); end
        n_checks++;
        if (in_TREADY !== 2'b11) begin n_fail++; $display("FAIL fwd_no_state: got %b want 11", in_TREADY); end
    endtask

    task automatic test_pause;
        in_TVALID  = 2'b11;
        out_TREADY = 2'b11;
        send_cmd(64'h00000001_00000070);
        #1;
        n_checks++;
        if (in_TREADY !== 2'b11) begin n_fail++; $display("FAIL pause_shadow_only: got %b want 11", in_TREADY); end
        send_cmd(64'h00000000_0000007F);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (in_TREADY !== 2'b01) begin n_fail++; $display("FAIL pause_ready[%0d]: got %b want 01", k, in_TREADY); end
            n_checks++;
            if (out_TVALID !== 2'b01) begin n_fail++; $display("FAIL pause_out_vld[%0d]: got %b want 01", k, out_TVALID); end
            @(negedge clk);
        end
    endtask

    task automatic test_pass_cnt;
        logic [63:0] d;
        logic        e;
        send_cmd(64'h00000003_00000073);
        send_cmd(64'h00000000_0000007F);
        for (int k = 0; k < 6; k++) begin
            d = 64'hC0DE_0000_0000_0000 + 64'(k);
            in_TDATA[127:64] = d;
            e = (k < 3);
            #1;
            n_checks++;
            if (in_TREADY[1] !== e) begin n_fail++; $display("FAIL pass_ready[%0d]: got %b want %b", k, in_TREADY[1], e); end
            n_checks++;
            if (out_TVALID[1] !== e) begin n_fail++; $display("FAIL pass_out_vld[%0d]: got %b want %b", k, out_TVALID[1], e); end
            n_checks++;
            if (out_TDATA[127:64] !== d) begin n_fail++; $display("FAIL pass_data[%0d]: got %h want %h", k, out_TDATA[127:64], d); end
            @(negedge clk);
        end
        send_cmd(64'h00000000_00000070);
        send_cmd(64'h00000000_0000007F);
        #1;
        n_checks++;
        if (in_TREADY !== 2'b11) begin n_fail++; $display("FAIL unpause_ready: got %b want 11", in_TREADY); end
    endtask

    task automatic test_drop;
        logic er, ev;
        send_cmd(64'h00000002_00000064);
        send_cmd(64'h00000000_0000006F);
        out_TREADY = 2'b10;
        for (int k = 0; k < 3; k++) begin
            er = (k < 2);
            ev = (k >= 2);
            #1;
            n_checks++;
            if (in_TREADY[0] !== er) begin n_fail++; $display("FAIL drop_ready[%0d]: got %b want %b", k, in_TREADY[0], er); end
            n_checks++;
            if (out_TVALID[0] !== ev) begin n_fail++; $display("FAIL drop_out_vld[%0d]: got %b want %b", k, out_TVALID[0], ev); end
            @(negedge clk);
        end
        out_TREADY = 2'b11;
        #1;
        n_checks++;
        if (in_TREADY !== 2'b11) begin n_fail++; $display("FAIL drop_done_ready: got %b want 11", in_TREADY); end
        n_checks++;
        if (out_TVALID[0] !== 1'b1) begin n_fail++; $display("FAIL drop_third_fwd: got %b want 1", out_TVALID[0]); end
    endtask

    task automatic test_log_merge;
        logic [63:0] d0, d1;
        logic [7:0]  k0, k1;
        logic        e0, e1, exp_dest;
        logic [71:0] exp_log;
        int          n0, n1;
        in_TVALID = 2'b00;
        send_cmd(64'h00000001_00000062);
        send_cmd(64'h00000001_00000072);
        send_cmd(64'h00000000_0000006E);
        log_TREADY = 1'b1;
        out_TREADY = 2'b11;
        in_TLAST   = 2'b01;
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 9; k++) begin
            d0 = 64'hA000_0000_0000_0000 + 64'(n0);
            d1 = 64'hB000_0000_0000_0000 + 64'(n1);
            k0 = 8'h10 + 8'(n0);
            k1 = 8'h20 + 8'(n1);
            in_TDATA  = {d1, d0};
            in_TKEEP  = {k1, k0};
            in_TVALID = 2'b11;
            e0 = (k == 0) || (k % 2 == 1);
            e1 = (k == 0) || (k % 2 == 0);
            #1;
            n_checks++;
            if (in_TREADY !== {e1, e0}) begin n_fail++; $display("FAIL log_ready[%0d]: got %b want %b", k, in_TREADY, {e1, e0}); end
            if (k == 0) begin
                n_checks++;
                if (log_TVALID !== 1'b0) begin n_fail++; $display("FAIL log_first_vld: got %b want 0", log_TVALID); end
            end else begin
                if (k % 2 == 1) begin
                    exp_dest = 1'b0;
                    exp_log  = {8'h10 + 8'((k - 1) / 2), 64'hA000_0000_0000_0000 + 64'((k - 1) / 2)};
                end else begin
                    exp_dest = 1'b1;
                    exp_log  = {8'h20 + 8'((k - 2) / 2), 64'hB000_0000_0000_0000 + 64'((k - 2) / 2)};
                end
                n_checks++;
                if (log_TVALID !== 1'b1) begin n_fail++; $display("FAIL log_vld[%0d]: got %b want 1", k, log_TVALID); end
                n_checks++;
                if (log_TDEST !== exp_dest) begin n_fail++; $display("FAIL log_dest[%0d]: got %0d want %0d", k, log_TDEST, exp_dest); end
                n_checks++;
                if (log_TDATA !== exp_log) begin n_fail++; $display("FAIL log_data[%0d]: got %h want %h", k, log_TDATA, exp_log); end
                n_checks++;
                if (log_TLAST !== !exp_dest) begin n_fail++; $display("FAIL log_last[%0d]: got %b want %b", k, log_TLAST, !exp_dest); end
            end
            if (e0) n0++;
            if (e1) n1++;
            @(negedge clk);
        end
        // drain both buffers
        in_TVALID = 2'b00;
        repeat (3) @(negedge clk);
        // stall: ch1 captured first, grant must stay on ch1 after ch0 fills
        log_TREADY = 1'b0;
        in_TVALID  = 2'b10;
        in_TDATA   = {64'hB000_0000_0000_0100, 64'hA000_0000_0000_0100};
        in_TKEEP   = {8'h2F, 8'h1F};
        #1;
        n_checks++;
        if (in_TREADY !== 2'b11) begin n_fail++; $display("FAIL stall_s0_ready: got %b want 11", in_TREADY); end
        @(negedge clk);
        in_TVALID = 2'b11;
        in_TDATA  = {64'hB000_0000_0000_0101, 64'hA000_0000_0000_0100};
        #1;
        n_checks++;
        if (log_TDEST !== 1'b1 || log_TVALID !== 1'b1) begin n_fail++; $display("FAIL stall_s1_grant: got vld %b dest %0d want vld 1 dest 1", log_TVALID, log_TDEST); end
        n_checks++;
        if (in_TREADY !== 2'b01) begin n_fail++; $display("FAIL stall_s1_ready: got %b want 01", in_TREADY); end
        @(negedge clk);
        #1;
        n_checks++;
        if (log_TDEST !== 1'b1) begin n_fail++; $display("FAIL stall_hold_dest: got %0d want 1", log_TDEST); end
        n_checks++;
        if (log_TDATA !== {8'h2F, 64'hB000_0000_0000_0100}) begin n_fail++; $display("FAIL stall_hold_data: got %h want %h", log_TDATA, {8'h2F, 64'hB000_0000_0000_0100}); end
        n_checks++;
        if (in_TREADY !== 2'b00) begin n_fail++; $display("FAIL stall_both_blocked: got %b want 00", in_TREADY); end
        @(negedge clk);
        log_TREADY = 1'b1;
        #1;
        n_checks++;
        if (in_TREADY !== 2'b10) begin n_fail++; $display("FAIL release_ready: got %b want 10", in_TREADY); end
        n_checks++;
        if (log_TDEST !== 1'b1) begin n_fail++; $display("FAIL release_dest: got %0d want 1", log_TDEST); end
        @(negedge clk);
        in_TVALID = 2'b00;
        #1;
        n_checks++;
        if (log_TDEST !== 1'b0 || log_TDATA !== {8'h1F, 64'hA000_0000_0000_0100}) begin
            n_fail++; $display("FAIL release_ch0: got dest %0d data %h want dest 0 data %h", log_TDEST, log_TDATA, {8'h1F, 64'hA000_0000_0000_0100});
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (log_TDEST !== 1'b1 || log_TDATA !== {8'h2F, 64'hB000_0000_0000_0101}) begin
            n_fail++; $display("FAIL release_ch1: got dest %0d data %h want dest 1 data %h", log_TDEST, log_TDATA, {8'h2F, 64'hB000_0000_0000_0101});
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (log_TVALID !== 1'b0) begin n_fail++; $display("FAIL release_empty: got %b want 0", log_TVALID); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        log_TREADY = 1'b0;
        in_TVALID  = 2'b11;
        @(negedge clk);
        #1;
        n_checks++;
        if (log_TVALID !== 1'b1 || in_TREADY !== 2'b00) begin
            n_fail++; $display("FAIL pre_reset_state: got vld %b ready %b want vld 1 ready 00", log_TVALID, in_TREADY);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (log_TVALID !== 1'b0) begin n_fail++; $display("FAIL mid_reset_log_vld: got %b want 0", log_TVALID); end
        n_checks++;
        if (in_TREADY !== 2'b11) begin n_fail++; $display("FAIL mid_reset_ready: got %b want 11", in_TREADY); end
        n_checks++;
        if (out_TVALID !== 2'b11) begin n_fail++; $display("FAIL mid_reset_out_vld: got %b want 11", out_TVALID); end
        n_checks++;
        if (cmd_out_TVALID !== 1'b0 || p_cmd_out_TVALID !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_cmd_vld: got %b/%b want 0/0", cmd_out_TVALID, p_cmd_out_TVALID);
        end
    endtask

    initial begin
        rst           = 1'b1;
        cmd_in_TDATA  = '0;
        cmd_in_TVALID = 1'b0;
        in_TDATA      = '0;
        in_TKEEP      = '0;
        in_TDEST      = {16'hD001, 16'hD000};
        in_TID        = {16'h1D01, 16'h1D00};
        in_TLAST      = '0;
        in_TVALID     = '0;
        out_TREADY    = '0;
        log_TREADY    = 1'b0;
        test_reset();
        test_cmd_fwd();
        test_pause();
        test_pass_cnt();
        test_drop();
        test_log_merge();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
